// File: rtl/arb_pkg.sv
// Shared types and constants for the pmem arbiter: FSM state encoding and arbitration modes.
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  localparam int MAX_CH = 8;

  localparam logic ARB_FIXED = 1'b0;
  localparam logic ARB_RR    = 1'b1;

endpackage

// File: rtl/pmem_arbiter_if.sv
// Bundle of the per-channel request/response bus and the single physical-memory port.
interface pmem_arbiter_if #(
  parameter int NUM_CH = 2,
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
);

  // Handshake: a channel holds ch_read/ch_write with stable addr/wdata until its one-cycle
  // ch_resp pulse; the arbiter holds pmem_read/pmem_write/addr/wdata until pmem_resp.
  logic [NUM_CH-1:0]             ch_read;
  logic [NUM_CH-1:0]             ch_write;
  logic [NUM_CH-1:0][ADDR_W-1:0] ch_addr;
  logic [NUM_CH-1:0][LINE_W-1:0] ch_wdata;
  logic [NUM_CH-1:0]             ch_resp;
  logic [LINE_W-1:0]             ch_rdata;
  logic                          pmem_read;
  logic                          pmem_write;
  logic [ADDR_W-1:0]             pmem_addr;
  logic [LINE_W-1:0]             pmem_wdata;
  logic                          pmem_resp;
  logic [LINE_W-1:0]             pmem_rdata;

  modport slave (
    input  ch_read, ch_write, ch_addr, ch_wdata, pmem_resp, pmem_rdata,
    output ch_resp, ch_rdata, pmem_read, pmem_write, pmem_addr, pmem_wdata
  );

  modport master (
    output ch_read, ch_write, ch_addr, ch_wdata, pmem_resp, pmem_rdata,
    input  ch_resp, ch_rdata, pmem_read, pmem_write, pmem_addr, pmem_wdata
  );

endinterface

// File: rtl/pmem_arbiter_rr_pick.sv
// Combinational winner selection: scans from ptr (round-robin) or from 0 (fixed priority).
module rr_pick
  import arb_pkg::*;
#(
  parameter  int NUM_CH = 2,
  localparam int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [IDX_W-1:0]  ptr,
  input  logic              rr_mode,
  output logic [NUM_CH-1:0] grant,
  output logic [IDX_W-1:0]  idx
);

  logic             found;
  int               start;
  int               c;
  logic [IDX_W-1:0] ci;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    start = 0;
    c     = 0;
    ci    = '0;
    if (rr_mode == ARB_RR) start = int'(ptr);
    for (int i = 0; i < NUM_CH; i++) begin
      c = start + i;
      if (c >= NUM_CH) c = c - NUM_CH;
      ci = IDX_W'(c);
      if (!found && req[ci]) begin
        found     = 1'b1;
        grant[ci] = 1'b1;
        idx       = ci;
      end
    end
  end

endmodule

// File: rtl/pmem_arbiter.sv
// N-channel cache-line arbiter onto one pmem port: IDLE picks a winner, BUSY holds the
// memory request until pmem_resp, RESP pulses the winner's ch_resp for one cycle.
module pmem_arbiter
  import arb_pkg::*;
#(
  parameter int NUM_CH  = 2,
  parameter int ADDR_W  = 32,
  parameter int LINE_W  = 256,
  parameter int RR_MODE = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  pmem_arbiter_if.slave bus,
  output arb_state_t state
);

  localparam int               IDX_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);
  localparam logic             MODE     = (RR_MODE != 0) ? ARB_RR : ARB_FIXED;

  arb_state_t        state_q, state_d;
  logic [NUM_CH-1:0] req, grant, grant_q, resp_q;
  logic [IDX_W-1:0]  pick_idx, idx_q, ptr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [LINE_W-1:0] wdata_q, rdata_q;
  logic              rd_q, wr_q;

  assign req = bus.ch_read | bus.ch_write;

  rr_pick #(.NUM_CH(NUM_CH)) u_pick (
    .req     (req),
    .ptr     (ptr_q),
    .rr_mode (MODE),
    .grant   (grant),
    .idx     (pick_idx)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (|req) state_d = BUSY;
      BUSY:    if (bus.pmem_resp) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A write wins over a simultaneous read on the same channel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      idx_q   <= '0;
      ptr_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      resp_q  <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: if (|req) begin
          grant_q <= grant;
          idx_q   <= pick_idx;
          addr_q  <= bus.ch_addr[pick_idx];
          wdata_q <= bus.ch_wdata[pick_idx];
          wr_q    <= bus.ch_write[pick_idx];
          rd_q    <= ~bus.ch_write[pick_idx];
        end
        BUSY: if (bus.pmem_resp) begin
          rd_q    <= 1'b0;
          wr_q    <= 1'b0;
          rdata_q <= bus.pmem_rdata;
          resp_q  <= grant_q;
        end
        RESP: begin
          resp_q <= '0;
          if (MODE == ARB_RR) ptr_q <= (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.pmem_read  = rd_q;
  assign bus.pmem_write = wr_q;
  assign bus.pmem_addr  = addr_q;
  assign bus.pmem_wdata = wdata_q;
  assign bus.ch_resp    = resp_q;
  assign bus.ch_rdata   = rdata_q;
  assign state          = state_q;

endmodule

// File: tb/tb_pmem_arbiter.sv
// Directed bench for pmem_arbiter: a 4-channel round-robin instance and a 2-channel
// fixed-priority instance, each with its own small pmem responder.
module tb_pmem_arbiter;
  import arb_pkg::*;

  logic clk;
  logic rst_n;
  arb_state_t state_rr, state_fp;

  pmem_arbiter_if #(.NUM_CH(4), .ADDR_W(32), .LINE_W(256)) bus_rr ();
  pmem_arbiter_if #(.NUM_CH(2), .ADDR_W(32), .LINE_W(256)) bus_fp ();

  pmem_arbiter #(.NUM_CH(4), .ADDR_W(32), .LINE_W(256), .RR_MODE(1)) dut_rr (
    .clk(clk), .rst_n(rst_n), .bus(bus_rr), .state(state_rr)
  );
  pmem_arbiter #(.NUM_CH(2), .ADDR_W(32), .LINE_W(256), .RR_MODE(0)) dut_fp (
    .clk(clk), .rst_n(rst_n), .bus(bus_fp), .state(state_fp)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [255:0] line_of(input logic [31:0] a);
    return {8{a ^ 32'hA5A5_A5A5}};
  endfunction

  function automatic int oh2i(input logic [3:0] oh);
    for (int i = 0; i < 4; i++) if (oh[i]) return i;
    return 0;
  endfunction

  // pmem responders: auto mode answers lat cycles into BUSY, manual mode follows man_* vars
  logic         auto_rr = 1'b0, auto_fp = 1'b0;
  int           lat_rr = 0, lat_fp = 0, cnt_rr = 0, cnt_fp = 0;
  logic         man_resp_rr = 1'b0, man_resp_fp = 1'b0;
  logic [255:0] man_rdata = '0;

  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_rr.pmem_resp = 1'b0; bus_rr.pmem_rdata = '0; cnt_rr = 0;
    end else if (!auto_rr) begin
      bus_rr.pmem_resp = man_resp_rr; bus_rr.pmem_rdata = man_rdata;
    end else if (bus_rr.pmem_read || bus_rr.pmem_write) begin
      bus_rr.pmem_resp  = (cnt_rr == lat_rr);
      bus_rr.pmem_rdata = line_of(bus_rr.pmem_addr);
      cnt_rr++;
    end else begin
      bus_rr.pmem_resp = 1'b0; cnt_rr = 0;
    end
  end

  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_fp.pmem_resp = 1'b0; bus_fp.pmem_rdata = '0; cnt_fp = 0;
    end else if (!auto_fp) begin
      bus_fp.pmem_resp = man_resp_fp; bus_fp.pmem_rdata = man_rdata;
    end else if (bus_fp.pmem_read || bus_fp.pmem_write) begin
      bus_fp.pmem_resp  = (cnt_fp == lat_fp);
      bus_fp.pmem_rdata = line_of(bus_fp.pmem_addr);
      cnt_fp++;
    end else begin
      bus_fp.pmem_resp = 1'b0; cnt_fp = 0;
    end
  end

  // driver tasks
  task automatic clear_inputs();
    bus_rr.ch_read = '0; bus_rr.ch_write = '0; bus_rr.ch_addr = '0; bus_rr.ch_wdata = '0;
    bus_fp.ch_read = '0; bus_fp.ch_write = '0; bus_fp.ch_addr = '0; bus_fp.ch_wdata = '0;
    man_resp_rr = 1'b0; man_resp_fp = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  logic [3:0]   resp_log[8];
  logic [255:0] data_log[8];
  int           log_n;

  // Requesters hold until their ch_resp, drop for the RESP cycle, then re-request.
  task automatic collect_rr(input logic [3:0] mask, input int n);
    logic [3:0] reraise;
    reraise = '0;
    log_n = 0;
    for (int i = 0; i < 4; i++) bus_rr.ch_addr[i] = 32'h1000 * (i + 1);
    bus_rr.ch_read = mask;
    for (int cyc = 0; cyc < n * 10 && log_n < n; cyc++) begin
      tick();
      bus_rr.ch_read = bus_rr.ch_read | reraise;
      reraise = '0;
      if (bus_rr.ch_resp != '0) begin
        resp_log[log_n] = bus_rr.ch_resp;
        data_log[log_n] = bus_rr.ch_rdata;
        log_n++;
        bus_rr.ch_read = bus_rr.ch_read & ~bus_rr.ch_resp;
        reraise = bus_rr.ch_resp;
      end
    end
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    tick();
    n_checks++; if (state_rr !== IDLE || state_fp !== IDLE) $display("FAIL reset_state: got %0d/%0d want IDLE", state_rr, state_fp); else n_pass++;
    n_checks++; if ({bus_rr.pmem_read, bus_rr.pmem_write, bus_fp.pmem_read, bus_fp.pmem_write} !== 4'b0) $display("FAIL reset_strobes: got %b%b%b%b want 0000", bus_rr.pmem_read, bus_rr.pmem_write, bus_fp.pmem_read, bus_fp.pmem_write); else n_pass++;
    n_checks++; if (bus_rr.ch_resp !== 4'b0 || bus_fp.ch_resp !== 2'b0) $display("FAIL reset_resp: got %b/%b want 0", bus_rr.ch_resp, bus_fp.ch_resp); else n_pass++;
    n_checks++; if (bus_rr.pmem_addr !== 32'h0 || bus_rr.pmem_wdata !== 256'h0 || bus_rr.ch_rdata !== 256'h0) $display("FAIL reset_data: addr %h wdata %h rdata %h want 0", bus_rr.pmem_addr, bus_rr.pmem_wdata, bus_rr.ch_rdata); else n_pass++;
    rst_n = 1'b1;
  endtask

  task automatic test_single_read();
    do_reset();
    auto_rr = 1'b0;
    bus_rr.ch_addr[1] = 32'h0000_0040;
    bus_rr.ch_read[1] = 1'b1;
    tick();
    n_checks++; if (bus_rr.pmem_read !== 1'b1 || bus_rr.pmem_write !== 1'b0) $display("FAIL rd_strobe: got r%b w%b want r1 w0", bus_rr.pmem_read, bus_rr.pmem_write); else n_pass++;
    n_checks++; if (bus_rr.pmem_addr !== 32'h40) $display("FAIL rd_addr: got %h want 00000040", bus_rr.pmem_addr); else n_pass++;
    man_rdata = {32{8'hA5}};
    man_resp_rr = 1'b1;
    tick();
    n_checks++; if (bus_rr.ch_resp !== 4'b0010) $display("FAIL rd_resp: got %b want 0010", bus_rr.ch_resp); else n_pass++;
    n_checks++; if (bus_rr.ch_rdata !== {32{8'hA5}}) $display("FAIL rd_data: got %h want a5..a5", bus_rr.ch_rdata); else n_pass++;
    n_checks++; if (bus_rr.pmem_read !== 1'b0) $display("FAIL rd_strobe_drop: got %b want 0", bus_rr.pmem_read); else n_pass++;
    man_resp_rr = 1'b0;
    bus_rr.ch_read[1] = 1'b0;
    tick();
    n_checks++; if (bus_rr.ch_resp !== 4'b0 || state_rr !== IDLE) $display("FAIL rd_resp_once: got %b state %0d want 0000 IDLE", bus_rr.ch_resp, state_rr); else n_pass++;
    n_checks++; if (bus_rr.ch_rdata !== {32{8'hA5}}) $display("FAIL rd_data_hold: got %h want a5..a5", bus_rr.ch_rdata); else n_pass++;
    man_resp_rr = 1'b1;
    tick();
    n_checks++; if (bus_rr.ch_resp !== 4'b0 || state_rr !== IDLE) $display("FAIL idle_resp_ignored: got %b state %0d want 0000 IDLE", bus_rr.ch_resp, state_rr); else n_pass++;
    man_resp_rr = 1'b0;
  endtask

  task automatic test_rr_two();
    logic [3:0] exp_seq[4];
    exp_seq = '{4'b0001, 4'b0010, 4'b0001, 4'b0010};
    do_reset();
    auto_rr = 1'b1;
    lat_rr = 1;
    collect_rr(4'b0011, 4);
    n_checks++; if (log_n !== 4) $display("FAIL rr2_timeout: got %0d responses want 4", log_n); else n_pass++;
    for (int i = 0; i < log_n; i++) begin
      n_checks++; if (resp_log[i] !== exp_seq[i]) $display("FAIL rr2_grant%0d: got %b want %b", i, resp_log[i], exp_seq[i]); else n_pass++;
      n_checks++; if (data_log[i] !== line_of(32'h1000 * (oh2i(exp_seq[i]) + 1))) $display("FAIL rr2_data%0d: got %h want %h", i, data_log[i], line_of(32'h1000 * (oh2i(exp_seq[i]) + 1))); else n_pass++;
    end
  endtask

  task automatic test_rr_four();
    logic [3:0] exp_seq[5];
    exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    do_reset();
    auto_rr = 1'b1;
    lat_rr = 0;
    collect_rr(4'b1111, 5);
    n_checks++; if (log_n !== 5) $display("FAIL rr4_timeout: got %0d responses want 5", log_n); else n_pass++;
    for (int i = 0; i < log_n; i++) begin
      n_checks++; if (resp_log[i] !== exp_seq[i]) $display("FAIL rr4_grant%0d: got %b want %b", i, resp_log[i], exp_seq[i]); else n_pass++;
    end
  endtask

  task automatic test_fixed();
    logic [1:0] fp_log[4];
    logic [1:0] exp_seq[4];
    logic [1:0] reraise;
    int         n;
    exp_seq = '{2'b01, 2'b01, 2'b01, 2'b10};
    do_reset();
    auto_fp = 1'b1;
    lat_fp = 0;
    bus_fp.ch_addr[0] = 32'h10;
    bus_fp.ch_addr[1] = 32'h20;
    bus_fp.ch_read = 2'b11;
    reraise = '0;
    n = 0;
    for (int cyc = 0; cyc < 60 && n < 4; cyc++) begin
      tick();
      bus_fp.ch_read = bus_fp.ch_read | reraise;
      reraise = '0;
      if (bus_fp.ch_resp != '0) begin
        fp_log[n] = bus_fp.ch_resp;
        bus_fp.ch_read = bus_fp.ch_read & ~bus_fp.ch_resp;
        if (bus_fp.ch_resp == 2'b01 && n < 2) reraise = 2'b01;
        n++;
      end
    end
    n_checks++; if (n !== 4) $display("FAIL fp_timeout: got %0d responses want 4", n); else n_pass++;
    for (int i = 0; i < n; i++) begin
      n_checks++; if (fp_log[i] !== exp_seq[i]) $display("FAIL fp_grant%0d: got %b want %b", i, fp_log[i], exp_seq[i]); else n_pass++;
    end
  endtask

  task automatic test_write();
    do_reset();
    auto_fp = 1'b0;
    bus_fp.ch_addr[0]  = 32'h100;
    bus_fp.ch_wdata[0] = 256'h1234;
    bus_fp.ch_write[0] = 1'b1;
    tick();
    n_checks++; if (bus_fp.pmem_write !== 1'b1 || bus_fp.pmem_read !== 1'b0) $display("FAIL wr_strobe: got r%b w%b want r0 w1", bus_fp.pmem_read, bus_fp.pmem_write); else n_pass++;
    n_checks++; if (bus_fp.pmem_addr !== 32'h100 || bus_fp.pmem_wdata !== 256'h1234) $display("FAIL wr_bus: got %h %h want 100 1234", bus_fp.pmem_addr, bus_fp.pmem_wdata); else n_pass++;
    bus_fp.ch_read[1]  = 1'b1;
    bus_fp.ch_addr[1]  = 32'hDEAD;
    bus_fp.ch_wdata[1] = 256'h5555;
    bus_fp.ch_addr[0]  = 32'h999;
    tick();
    n_checks++; if (bus_fp.pmem_addr !== 32'h100 || bus_fp.pmem_wdata !== 256'h1234 || state_fp !== BUSY) $display("FAIL wr_stable: got %h %h state %0d want 100 1234 BUSY", bus_fp.pmem_addr, bus_fp.pmem_wdata, state_fp); else n_pass++;
    man_resp_fp = 1'b1;
    tick();
    n_checks++; if (bus_fp.ch_resp !== 2'b01 || bus_fp.pmem_write !== 1'b0) $display("FAIL wr_resp: got %b w%b want 01 w0", bus_fp.ch_resp, bus_fp.pmem_write); else n_pass++;
    man_resp_fp = 1'b0;
    bus_fp.ch_write[0] = 1'b0;
    tick();
    n_checks++; if (bus_fp.ch_resp !== 2'b00 || state_fp !== IDLE || bus_fp.pmem_read !== 1'b0) $display("FAIL wr_idle_gap: got %b state %0d r%b want 00 IDLE r0", bus_fp.ch_resp, state_fp, bus_fp.pmem_read); else n_pass++;
    tick();
    n_checks++; if (bus_fp.pmem_read !== 1'b1 || bus_fp.pmem_addr !== 32'hDEAD) $display("FAIL wr_next_grant: got r%b %h want r1 0000dead", bus_fp.pmem_read, bus_fp.pmem_addr); else n_pass++;
  endtask

  task automatic test_rw_conflict();
    do_reset();
    auto_fp = 1'b0;
    bus_fp.ch_addr[1]  = 32'h300;
    bus_fp.ch_wdata[1] = 256'hBEEF;
    bus_fp.ch_read[1]  = 1'b1;
    bus_fp.ch_write[1] = 1'b1;
    tick();
    n_checks++; if (bus_fp.pmem_write !== 1'b1 || bus_fp.pmem_read !== 1'b0 || bus_fp.pmem_wdata !== 256'hBEEF) $display("FAIL rw_conflict: got r%b w%b %h want r0 w1 beef", bus_fp.pmem_read, bus_fp.pmem_write, bus_fp.pmem_wdata); else n_pass++;
  endtask

  task automatic test_reset_mid_busy();
    logic found;
    do_reset();
    auto_rr = 1'b1;
    lat_rr = 0;
    for (int i = 0; i < 4; i++) bus_rr.ch_addr[i] = 32'h1000 * (i + 1);
    bus_rr.ch_read[1] = 1'b1;
    found = 1'b0;
    for (int cyc = 0; cyc < 10 && !found; cyc++) begin
      tick();
      if (bus_rr.ch_resp != '0) found = 1'b1;
    end
    n_checks++; if (!found || bus_rr.ch_resp !== 4'b0010) $display("FAIL rst_pre_resp: got %b want 0010", bus_rr.ch_resp); else n_pass++;
    bus_rr.ch_read = '0;
    tick();
    lat_rr = 6;
    bus_rr.ch_read = 4'b0101;
    tick();
    n_checks++; if (bus_rr.pmem_read !== 1'b1 || bus_rr.pmem_addr !== 32'h3000) $display("FAIL rst_ptr_grant: got r%b %h want r1 00003000", bus_rr.pmem_read, bus_rr.pmem_addr); else n_pass++;
    tick();
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (bus_rr.pmem_read !== 1'b0 || bus_rr.ch_resp !== 4'b0 || state_rr !== IDLE) $display("FAIL rst_async: got r%b %b state %0d want r0 0000 IDLE", bus_rr.pmem_read, bus_rr.ch_resp, state_rr); else n_pass++;
    n_checks++; if (bus_rr.pmem_addr !== 32'h0) $display("FAIL rst_async_addr: got %h want 0", bus_rr.pmem_addr); else n_pass++;
    tick();
    tick();
    rst_n = 1'b1;
    lat_rr = 0;
    found = 1'b0;
    for (int cyc = 0; cyc < 10 && !found; cyc++) begin
      tick();
      if (bus_rr.ch_resp != '0) found = 1'b1;
    end
    n_checks++; if (!found || bus_rr.ch_resp !== 4'b0001) $display("FAIL rst_restart: got %b want 0001", bus_rr.ch_resp); else n_pass++;
  endtask

  // final report
  initial begin
    rst_n = 1'b0;
    clear_inputs();
    test_reset();
    test_single_read();
    test_rr_two();
    test_rr_four();
    test_fixed();
    test_write();
    test_rw_conflict();
    test_reset_mid_busy();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
